riscv_lsu: RTL

//  RV32I load/store unit, directly downstream of riscv_alu in the execute/memory path.
//  - Consumes o_alu_result as the effective address and rs2 as store data.
//  - Runs one word-aligned access on a simple req/ack data-memory bus.
//  - Returns sign- or zero-extended load data with a one-cycle done pulse.
//  - Flags misaligned, illegal-funct3 and bus-timeout accesses.

---
 rtl/riscv_lsu_pkg.sv | 23 ++
 rtl/riscv_lsu_align.sv | 78 +++++++
 rtl/riscv_lsu.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
// Holds datapath width, funct3 codes and the LSU state encoding.
package riscv_lsu_pkg;

  localparam int XLEN = 32;
  localparam int NBE  = XLEN / 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: store be/wdata/misalign/illegal, load extract.
// Ports: we, funct3, off, rs2, rdata in; be, wdata, misalign, illegal, ldata out.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] rdata,
  output logic [NBE-1:0]  be,
  output logic [XLEN-1:0] wdata,
  output logic            misalign,
  output logic            illegal,
  output logic [XLEN-1:0] ldata
);

  logic            sz_b;
  logic            sz_h;
  logic            sz_w;
  logic [XLEN-1:0] d;

  assign sz_b = (funct3[1:0] == 2'b00);
  assign sz_h = (funct3[1:0] == 2'b01);
  assign sz_w = (funct3[1:0] == 2'b10);

  // loads reject 011/110/111, stores reject everything above SW
  always_comb begin
    if (we)
      illegal = funct3[2] | (&funct3[1:0]);
    else
      illegal = (&funct3[1:0]) | (funct3[2] & funct3[1]);
  end

  assign misalign = !illegal &&
                    ((sz_h && off[0]) ||
                     (sz_w && (off != 2'b00)));

  always_comb begin
    be    = '1;
    wdata = rs2;
    if (we) begin
      unique case (1'b1)
        sz_b: begin
          be    = 4'b0001 << off;
          wdata = {4{rs2[7:0]}};
        end
        sz_h: begin
          be    = 4'b0011 << off;
          wdata = {2{rs2[15:0]}};
        end
        default: begin
          be    = '1;
          wdata = rs2;
        end
      endcase
    end
  end

  assign d = rdata >> {off, 3'b000};

  always_comb begin
    ldata = d;
    unique case (1'b1)
      (funct3 == F3_LB):
        ldata = {{24{d[7]}}, d[7:0]};
      (funct3 == F3_LH):
        ldata = {{16{d[15]}}, d[15:0]};
      (funct3 == F3_LBU):
        ldata = {24'h0, d[7:0]};
      (funct3 == F3_LHU):
        ldata = {16'h0, d[15:0]};
      default:
        ldata = d;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one word-aligned access per request on req/ack bus.
// Ports: i_lsu_* request, o_lsu_* result/handshake, o_dmem_*/i_dmem_* bus.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_lsu_valid,
  input  logic            i_lsu_we,
  input  logic [2:0]      i_lsu_funct3,
  input  logic [XLEN-1:0] i_lsu_addr,
  input  logic [XLEN-1:0] i_lsu_wdata,
  output logic            o_lsu_ready,
  output logic            o_lsu_done,
  output logic [XLEN-1:0] o_lsu_rdata,
  output logic            o_lsu_err,
  output logic            o_lsu_misalign,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [NBE-1:0]  o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_ack,
  input  logic [XLEN-1:0] i_dmem_rdata
);

  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

  lsu_state_t      state;
  lsu_state_t      state_d;
  logic [7:0]      cnt;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [NBE-1:0]  be_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] res_rdata;
  logic            res_err;
  logic            res_mis;
  logic            done_q;

  logic            al_we;
  logic [2:0]      al_f3;
  logic [1:0]      al_off;
  logic [NBE-1:0]  al_be;
  logic [XLEN-1:0] al_wdata;
  logic            al_mis;
  logic            al_ill;
  logic [XLEN-1:0] al_ldata;
  logic            idle;
  logic            accept;
  logic            bad;

  assign idle   = (state == LSU_IDLE);
  assign accept = idle && i_lsu_valid;

  // store path decodes the live request, load path the held one
  assign al_we  = idle ? i_lsu_we : we_q;
  assign al_f3  = idle ? i_lsu_funct3 : f3_q;
  assign al_off = idle ? i_lsu_addr[1:0] : off_q;
  assign bad    = al_ill | al_mis;

  riscv_lsu_align u_align (
    .we       (al_we),
    .funct3   (al_f3),
    .off      (al_off),
    .rs2      (i_lsu_wdata),
    .rdata    (i_dmem_rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .misalign (al_mis),
    .illegal  (al_ill),
    .ldata    (al_ldata)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= LSU_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      LSU_IDLE: begin
        if (i_lsu_valid)
          state_d = bad ? LSU_DONE : LSU_REQ;
      end
      LSU_REQ: begin
        if (i_dmem_ack || cnt == LAST)
          state_d = LSU_DONE;
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt       <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      res_rdata <= '0;
      res_err   <= 1'b0;
      res_mis   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state == LSU_DONE);
      if (accept) begin
        we_q      <= i_lsu_we;
        f3_q      <= i_lsu_funct3;
        off_q     <= i_lsu_addr[1:0];
        be_q      <= i_lsu_we ? al_be : '1;
        wdata_q   <= al_wdata;
        addr_q    <= {i_lsu_addr[XLEN-1:2], 2'b00};
        cnt       <= '0;
        res_rdata <= '0;
        res_err   <= bad;
        res_mis   <= al_mis;
      end else if (state == LSU_REQ) begin
        if (i_dmem_ack) begin
          res_rdata <= we_q ? '0 : al_ldata;
          res_err   <= 1'b0;
        end else if (cnt == LAST) begin
          res_rdata <= '0;
          res_err   <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  assign o_lsu_ready    = idle;
  assign o_lsu_done     = done_q;
  assign o_lsu_rdata    = done_q ? res_rdata : '0;
  assign o_lsu_err      = done_q & res_err;
  assign o_lsu_misalign = done_q & res_mis;

  assign o_dmem_req   = (state == LSU_REQ);
  assign o_dmem_we    = o_dmem_req & we_q;
  assign o_dmem_addr  = o_dmem_req ? addr_q : '0;
  assign o_dmem_be    = o_dmem_req ? be_q : '0;
  assign o_dmem_wdata = o_dmem_req ? wdata_q : '0;

endmodule
